// File: rtl/axis_fifo_pkg.sv
// Shared definitions for the synchronous AXI-stream FIFO (read and write sides).
package axis_fifo_pkg;

  localparam int unsigned ALEN_DEF = 8;
  localparam int unsigned INCR_DEF = 1;
  localparam int unsigned DLEN_DEF = 32;
  localparam int unsigned OCC_W    = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

  // Number of words held by the output buffer in a given state.
  function automatic logic [OCC_W-1:0] state_occ(input buf_state_e s);
    logic [OCC_W-1:0] occ;
    case (s)
      ONE:     occ = OCC_W'(1);
      TWO:     occ = OCC_W'(2);
      default: occ = OCC_W'(0);
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/axis_fifo_out_skid.sv
// Two-entry output buffer (main + skid slot) driving the AXI-stream master side.
module axis_fifo_out_skid
  import axis_fifo_pkg::*;
#(
  parameter int unsigned DLEN = DLEN_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             capture,
  input  logic [DLEN-1:0]  rdata,
  input  logic             i_tready,
  output logic             o_tvalid,
  output logic [DLEN-1:0]  o_tdata,
  output logic [OCC_W-1:0] occupancy
);

  buf_state_e      state_q;
  buf_state_e      state_d;
  logic [DLEN-1:0] main_d;
  logic [DLEN-1:0] skid_q;
  logic [DLEN-1:0] skid_d;
  logic            pop;

  assign pop = o_tvalid & i_tready;

  // State and slot registers; o_tdata is the main slot itself.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= EMPTY;
      o_tvalid  <= 1'b0;
      o_tdata   <= '0;
      skid_q    <= '0;
      occupancy <= '0;
    end else begin
      state_q   <= state_d;
      o_tvalid  <= (state_d != EMPTY);
      o_tdata   <= main_d;
      skid_q    <= skid_d;
      occupancy <= state_occ(state_d);
    end
  end

  // Next state: incoming word lands in the first slot still free after a pop.
  always_comb begin
    state_d = state_q;
    main_d  = o_tdata;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (capture) begin
          main_d  = rdata;
          state_d = ONE;
        end
      end
      ONE: begin
        if (capture && pop) begin
          main_d = rdata;
        end else if (capture) begin
          skid_d  = rdata;
          state_d = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          main_d = skid_q;
          if (capture) begin
            skid_d = rdata;
          end else begin
            state_d = ONE;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

endmodule

// File: rtl/axis_fifo_rd_ptr.sv
// Read-side controller: read pointer, empty/level detection, credit-based RAM reads.
module axis_fifo_rd_ptr
  import axis_fifo_pkg::*;
#(
  parameter int unsigned ALEN = ALEN_DEF,
  parameter int unsigned INCR = INCR_DEF,
  parameter int unsigned DLEN = DLEN_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [ALEN:0]   i_wptr,
  output logic [ALEN:0]   o_rptr,
  output logic [ALEN-1:0] o_raddr,
  output logic            o_ram_ren,
  input  logic [DLEN-1:0] i_ram_rdata,
  output logic            o_rempty,
  output logic [ALEN:0]   o_rlevel,
  output logic            o_tvalid,
  input  logic            i_tready,
  output logic [DLEN-1:0] o_tdata
);

  localparam int unsigned PW = ALEN + 1;
  localparam int unsigned CW = 3;

  logic             inflight_q;
  logic [OCC_W-1:0] occ;
  logic             pop;
  logic [CW-1:0]    credit_c;

  assign o_raddr  = o_rptr[ALEN-1:0];
  assign o_rempty = (o_rptr == i_wptr);
  assign o_rlevel = i_wptr - o_rptr;
  assign pop      = o_tvalid & i_tready;

  // Read only while the buffer plus the word in flight, less this cycle's pop, has room.
  always_comb begin
    credit_c  = CW'(occ) + CW'(inflight_q) - CW'(pop);
    o_ram_ren = ~o_rempty & (credit_c < CW'(2));
  end

  // Pointer advance and in-flight tracking for the 1-cycle RAM latency.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      o_rptr     <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= o_ram_ren;
      if (o_ram_ren) begin
        o_rptr <= o_rptr + PW'(INCR);
      end
    end
  end

  axis_fifo_out_skid #(
    .DLEN (DLEN)
  ) u_out_skid (
    .clk       (clk),
    .rstn      (rstn),
    .capture   (inflight_q),
    .rdata     (i_ram_rdata),
    .i_tready  (i_tready),
    .o_tvalid  (o_tvalid),
    .o_tdata   (o_tdata),
    .occupancy (occ)
  );

endmodule

// File: tb/tb_axis_fifo_rd_ptr.sv
// Bench for the FIFO read side: RAM model, write-side stimulus, queue-based reference.
module tb_axis_fifo_rd_ptr;

  localparam int unsigned AL    = 8;
  localparam int unsigned PW    = AL + 1;
  localparam int unsigned DL    = 32;
  localparam int unsigned DEPTH = 1 << AL;

  logic clk;
  logic rstn;

  logic [PW-1:0] wptr, rptr, rlevel;
  logic [AL-1:0] raddr;
  logic          ren, rempty, tvalid, tready;
  logic [DL-1:0] rdata, tdata;
  logic [DL-1:0] mem [DEPTH];

  logic [2:0]    wptr_s, rptr_s, rlevel_s;
  logic [1:0]    raddr_s;
  logic          ren_s, rempty_s, tvalid_s, tready_s;
  logic [DL-1:0] rdata_s, tdata_s;
  logic [DL-1:0] mem_s [4];

  logic [DL-1:0] q[$];
  int            written, delivered, total, bad;
  logic          prev_valid, prev_ready;
  logic [DL-1:0] prev_data;

  axis_fifo_rd_ptr #(.ALEN(AL), .INCR(1), .DLEN(DL)) dut (
    .clk(clk), .rstn(rstn), .i_wptr(wptr), .o_rptr(rptr), .o_raddr(raddr),
    .o_ram_ren(ren), .i_ram_rdata(rdata), .o_rempty(rempty), .o_rlevel(rlevel),
    .o_tvalid(tvalid), .i_tready(tready), .o_tdata(tdata)
  );

  axis_fifo_rd_ptr #(.ALEN(2), .INCR(1), .DLEN(DL)) dut_s (
    .clk(clk), .rstn(rstn), .i_wptr(wptr_s), .o_rptr(rptr_s), .o_raddr(raddr_s),
    .o_ram_ren(ren_s), .i_ram_rdata(rdata_s), .o_rempty(rempty_s), .o_rlevel(rlevel_s),
    .o_tvalid(tvalid_s), .i_tready(tready_s), .o_tdata(tdata_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAMs with one cycle read latency.
  always @(posedge clk) if (ren) rdata <= mem[raddr];
  always @(posedge clk) if (ren_s) rdata_s <= mem_s[raddr_s];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [DL-1:0] d);
    mem[wptr[AL-1:0]] = d;
    q.push_back(d);
    wptr = wptr + PW'(1);
    written++;
  endtask

  // Per-cycle checks on the large instance, sampled mid-cycle.
  task automatic sb();
    int taken;
    if (!rstn) begin
      prev_valid = 1'b0;
      return;
    end
    if (prev_valid && !prev_ready) begin
      chk("hold_valid", 64'(tvalid), 64'd1);
      chk("hold_data", 64'(tdata), 64'(prev_data));
    end
    chk("rlevel", 64'(rlevel), 64'(PW'(wptr - rptr)));
    chk("rempty", 64'(rempty), 64'(wptr == rptr));
    chk("no_read_when_empty", 64'(ren & rempty), 64'd0);
    taken = written - delivered - int'(rlevel);
    chk("bounded_prefetch", 64'(taken >= 0 && taken <= 2), 64'd1);
    if (tvalid && tready) begin
      chk("beat_has_source", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        chk("beat_data", 64'(tdata), 64'(q.pop_front()));
        delivered++;
      end
    end
    prev_valid = tvalid;
    prev_ready = tready;
    prev_data  = tdata;
  endtask

  task automatic chk_pt();
    @(negedge clk);
    sb();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_s(input logic [DL-1:0] base);
    int got;
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      chk_pt();
      if (tvalid_s && tready_s) begin
        chk("small_beat", 64'(tdata_s), 64'(base + DL'(got)));
        got++;
      end
      adv();
    end
    chk("small_beat_count", 64'(got), 64'd4);
  endtask

  initial begin
    int n;
    int c;
    rstn = 1'b0; wptr = '0; tready = 1'b0; wptr_s = '0; tready_s = 1'b0;
    written = 0; delivered = 0; total = 0; bad = 0;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tvalid", 64'(tvalid), 64'd0);
    chk("reset_rptr", 64'(rptr), 64'd0);
    rstn = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      chk_pt();
      chk("idle_rempty", 64'(rempty), 64'd1);
      chk("idle_ren", 64'(ren), 64'd0);
      chk("idle_tvalid", 64'(tvalid), 64'd0);
      chk("idle_rptr", 64'(rptr), 64'd0);
      if (i == 0) chk("reset_tdata", 64'(tdata), 64'd0);
      adv();
    end

    // Single word latency.
    tready = 1'b1;
    wr(32'hA5A5_A5A5);
    chk_pt();
    chk("lat_ren_c0", 64'(ren), 64'd1);
    chk("lat_valid_c0", 64'(tvalid), 64'd0);
    adv();
    chk_pt();
    chk("lat_rptr_c1", 64'(rptr), 64'd1);
    chk("lat_rempty_c1", 64'(rempty), 64'd1);
    chk("lat_valid_c1", 64'(tvalid), 64'd0);
    adv();
    chk("lat_valid_c2", 64'(tvalid), 64'd1);
    chk("lat_data_c2", 64'(tdata), 64'hA5A5_A5A5);
    chk_pt();
    adv();
    chk_pt();
    chk("lat_valid_c3", 64'(tvalid), 64'd0);
    adv();

    // Eight preloaded words, consumer always ready: back-to-back beats.
    for (int i = 0; i < 8; i++) wr(32'h1000_0000 + DL'(i));
    for (int k = 0; k < 12; k++) begin
      chk_pt();
      chk("burst_valid", 64'(tvalid), 64'(k >= 2 && k <= 9));
      adv();
    end
    chk("burst_rptr", 64'(rptr), 64'd9);
    chk("burst_rempty", 64'(rempty), 64'd1);

    // Eight preloaded words, consumer stalled: only two reads issued.
    tready = 1'b0;
    for (int i = 0; i < 8; i++) wr(32'h2000_0000 + DL'(i));
    repeat (6) begin chk_pt(); adv(); end
    chk("stall_rptr", 64'(rptr), 64'd11);
    chk("stall_rlevel", 64'(rlevel), 64'd6);
    chk("stall_valid", 64'(tvalid), 64'd1);
    chk("stall_data", 64'(tdata), 64'h2000_0000);
    tready = 1'b1;
    repeat (12) begin chk_pt(); adv(); end
    chk("stall_drained", 64'(q.size()), 64'd0);
    chk("stall_rptr_end", 64'(rptr), 64'd17);
    chk("stall_delivered", 64'(delivered), 64'd17);

    // Small RAM: full boundary and wrap bit.
    for (int i = 0; i < 4; i++) mem_s[i] = 32'hC000_0000 + DL'(i);
    wptr_s = 3'b100;
    chk_pt();
    chk("small_full_level", 64'(rlevel_s), 64'd4);
    chk("small_full_rempty", 64'(rempty_s), 64'd0);
    adv();
    tready_s = 1'b1;
    drain_s(32'hC000_0000);
    chk("small_wrap_rptr", 64'(rptr_s), 64'b100);
    chk("small_wrap_rempty", 64'(rempty_s), 64'd1);
    for (int i = 0; i < 4; i++) mem_s[i] = 32'hD000_0000 + DL'(i);
    wptr_s = 3'b000;
    chk_pt();
    chk("small_full2_level", 64'(rlevel_s), 64'd4);
    adv();
    drain_s(32'hD000_0000);
    chk("small_rptr_zero", 64'(rptr_s), 64'd0);
    chk("small_rempty_end", 64'(rempty_s), 64'd1);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      tready = (i % 500 < 100) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
      n = int'($urandom_range(0, 2));
      for (int j = 0; j < n; j++) if (PW'(wptr - rptr) < PW'(DEPTH)) wr($urandom());
      chk_pt();
      adv();
    end

    // Stall and fill the RAM completely.
    tready = 1'b0;
    c = 0;
    while (PW'(wptr - rptr) < PW'(DEPTH) && c < 400) begin
      for (int j = 0; j < 2; j++) if (PW'(wptr - rptr) < PW'(DEPTH)) wr($urandom());
      chk_pt();
      adv();
      c++;
    end
    chk_pt();
    chk("full_level", 64'(rlevel), 64'(DEPTH));
    chk("full_rempty", 64'(rempty), 64'd0);
    adv();

    for (int i = 0; i < 1500; i++) begin
      tready = ($urandom_range(0, 3) != 0);
      n = int'($urandom_range(0, 2));
      for (int j = 0; j < n; j++) if (PW'(wptr - rptr) < PW'(DEPTH)) wr($urandom());
      chk_pt();
      adv();
    end

    // Drain everything.
    tready = 1'b1;
    c = 0;
    while ((q.size() != 0 || tvalid) && c < 800) begin
      chk_pt();
      adv();
      c++;
    end
    chk("drain_queue_empty", 64'(q.size()), 64'd0);
    chk("drain_rempty", 64'(rempty), 64'd1);
    chk("drain_tvalid", 64'(tvalid), 64'd0);

    // Reset with both buffer slots full.
    tready = 1'b0;
    for (int i = 0; i < 5; i++) wr(32'h3000_0000 + DL'(i));
    repeat (5) begin chk_pt(); adv(); end
    chk("pre_reset_level", 64'(rlevel), 64'd3);
    chk("pre_reset_valid", 64'(tvalid), 64'd1);
    rstn = 1'b0;
    wptr = '0;
    q.delete();
    written = 0;
    delivered = 0;
    chk_pt();
    adv();
    rstn = 1'b1;
    tready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk_pt();
      chk("post_reset_valid", 64'(tvalid), 64'd0);
      chk("post_reset_ren", 64'(ren), 64'd0);
      if (i == 0) begin
        chk("post_reset_rptr", 64'(rptr), 64'd0);
        chk("post_reset_tdata", 64'(tdata), 64'd0);
      end
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
